// File: rtl/mem_req_ctrl_if.sv
// Request, response and memory-pin bundle for mem_req_ctrl.
// The master side is the requester/memory environment; the slave side is the controller.
interface mem_req_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [DATA_WIDTH-1:0] mem_data_out;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
      input  req_ready, rsp_valid, rsp_addr, rsp_rdata,
      input  mem_read, mem_write, mem_addr, mem_data_in
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
      output req_ready, rsp_valid, rsp_addr, rsp_rdata,
      output mem_read, mem_write, mem_addr, mem_data_in
   );
endinterface

// File: rtl/mem_req_ctrl.sv
// Buffers single-beat read/write requests in a FIFO and replays them one at a time
// onto a 32 x 8 memory, with a recovery gap after every access.
module mem_req_ctrl #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic          clk,
   input  logic          rst,
   mem_req_ctrl_if.slave bus,
   output logic          busy,
   output logic [7:0]    wr_count,
   output logic [7:0]    rd_count
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0]       WAIT_LAST  = 3'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      WAIT,
      RSP,
      GAP
   } state_t;

   state_t state;
   state_t next_state;

   logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_empty;
   logic                  req_ready_int;
   logic                  push;
   logic                  pop;

   logic [ENTRY_W-1:0]    head_entry;
   logic                  head_write;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;

   logic                  mem_read_int;
   logic                  mem_write_int;
   logic                  rsp_valid_int;
   logic                  rsp_done;
   logic                  wait_done;
   logic [2:0]            wait_cnt;

   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_data_q;
   logic [ADDR_WIDTH-1:0] rsp_addr_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   // Ready comes only from the registered count, so there is no valid-to-ready path.
   assign req_ready_int = (fifo_count != FULL_COUNT);
   assign fifo_empty    = (fifo_count == '0);
   assign push          = bus.req_valid && req_ready_int;

   assign head_entry = fifo_mem[rd_ptr];
   assign head_write = head_entry[ENTRY_W-1];
   assign head_addr  = head_entry[ENTRY_W-2 -: ADDR_WIDTH];
   assign head_wdata = head_entry[DATA_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {bus.req_write, bus.req_addr, bus.req_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + CNT_W'(1);
         end else if (pop && !push) begin
            fifo_count <= fifo_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   assign wait_done = (wait_cnt == WAIT_LAST);
   assign rsp_done  = rsp_valid_int && bus.rsp_ready;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!fifo_empty) next_state = head_write ? WRITE : READ;
         WRITE:   next_state = GAP;
         READ:    next_state = WAIT;
         WAIT:    if (wait_done) next_state = RSP;
         RSP:     if (bus.rsp_ready) next_state = GAP;
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      mem_read_int  = 1'b0;
      mem_write_int = 1'b0;
      rsp_valid_int = 1'b0;
      pop           = 1'b0;
      case (state)
         IDLE:    pop = !fifo_empty;
         WRITE:   mem_write_int = 1'b1;
         READ:    mem_read_int = 1'b1;
         RSP:     rsp_valid_int = 1'b1;
         default: ;
      endcase
   end

   // Address/data registers only move on a pop or a read capture, so they hold between accesses.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         rsp_addr_q  <= '0;
         rsp_rdata_q <= '0;
         wait_cnt    <= '0;
         wr_count    <= '0;
         rd_count    <= '0;
      end else begin
         if (pop) begin
            mem_addr_q <= head_addr;
            mem_data_q <= head_wdata;
         end
         if (state == READ) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 3'd1;
         end
         if ((state == WAIT) && wait_done) begin
            rsp_addr_q  <= mem_addr_q;
            rsp_rdata_q <= bus.mem_data_out;
         end
         if ((state == WRITE) && (wr_count != 8'hFF)) begin
            wr_count <= wr_count + 8'd1;
         end
         if (rsp_done && (rd_count != 8'hFF)) begin
            rd_count <= rd_count + 8'd1;
         end
      end
   end

   assign bus.req_ready   = req_ready_int;
   assign bus.rsp_valid   = rsp_valid_int;
   assign bus.rsp_addr    = rsp_addr_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.mem_read    = mem_read_int;
   assign bus.mem_write   = mem_write_int;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_data_in = mem_data_q;
   assign busy            = (state != IDLE) || !fifo_empty;
endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request-driven controller that sits directly upstream of the 32 x 8 memory and drives its read/write/addr/data_in pins. It accepts single-beat read/write requests over a valid/ready port and buffers them in a small FIFO. It replays each request onto the memory with the one-cycle recovery gap the memory requires, and returns read data over a valid/ready response port. Saturating operation counters are exposed for functional-coverage sampling.

## Interface
- ADDR_WIDTH, 5, memory address width (32 locations)
- DATA_WIDTH, 8, memory data width
- FIFO_DEPTH, 4, request FIFO entries; power of two, 2..16
- READ_LATENCY, 1, cycles from mem_read sampled high to mem_data_out valid; 1..4

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request FIFO can accept
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  read response present
- rsp_ready  in  1  consumer accepts response
- rsp_addr  out  ADDR_WIDTH  address of returned read
- rsp_rdata  out  DATA_WIDTH  read data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data_in  out  DATA_WIDTH  memory write data
- mem_data_out  in  DATA_WIDTH  memory read data
- busy  out  1  FSM not in IDLE or FIFO non-empty
- wr_count  out  8  completed writes, saturating
- rd_count  out  8  completed reads (response handshakes), saturating

## Operation
- Request FIFO: push on req_valid && req_ready. req_ready = (count != FIFO_DEPTH), driven from the registered count with no combinational path from req_valid. A simultaneous push and pop leaves the count unchanged. No push is possible when full.
- FSM states: IDLE, WRITE, READ, WAIT, RSP, GAP.
  - IDLE: if FIFO non-empty, pop the head and load mem_addr/mem_data_in. Go to WRITE if the head is a write, else READ.
  - WRITE: mem_write=1 for exactly 1 cycle, then GAP. wr_count increments at the end of WRITE.
  - READ: mem_read=1 for exactly 1 cycle, then WAIT.
  - WAIT: READ_LATENCY cycles. mem_data_out is captured into rsp_rdata at the end of the last WAIT cycle, then RSP.
  - RSP: rsp_valid=1. rsp_addr/rsp_rdata are held stable until rsp_ready. On handshake, rd_count increments and the FSM goes to GAP.
  - GAP: all strobes low for 1 cycle, then IDLE.
- mem_read and mem_write are never high together. Both are low in IDLE, WAIT, RSP and GAP.
- mem_addr/mem_data_in hold their last loaded values outside strobe cycles.
- Only one request is in flight. The FIFO keeps accepting while the FSM is busy.
- Counters saturate at 255 and never wrap.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_addr=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_data_in=0, busy=0, wr_count=0, rd_count=0. FSM=IDLE, FIFO empty.
- Handshake in cycle k with the FSM idle and the FIFO empty:
  - entry visible in cycle k+1 (IDLE pops);
  - strobe high in cycle k+2.
- Write throughput: 3 cycles per write (IDLE, WRITE, GAP).
- Read with READ_LATENCY=L: READ in k+2, WAIT k+3..k+2+L, rsp_valid from k+3+L. With L=1, rsp_valid first high in k+4.
- Response backpressure: rsp_valid stays high with stable data. No new memory access is issued until the handshake completes.
- Reset asserted mid-operation:
  - strobes and rsp_valid are low in the cycle after the reset edge;
  - the FIFO is flushed and the pending response dropped;
  - counters return to 0.
- Address wrap: addresses are used verbatim. 0 and 2^ADDR_WIDTH-1 are legal with no special handling.

## Test plan
- Write 0xA5 to addr 5, then read addr 5 → mem_write high exactly 1 cycle with mem_addr=5, mem_data_in=0xA5; later rsp_valid with rsp_addr=5, rsp_rdata=0xA5, 4 cycles after the read handshake; wr_count=1, rd_count=1.
- Back-to-back: 6 writes offered on consecutive cycles with default params → req_ready drops after the FIFO fills and returns as entries drain; all 6 writes appear on the memory pins in order, spaced 3 cycles apart; no strobe overlap.
- Response backpressure: read addr 31 (preloaded 0x3C), hold rsp_ready=0 for 10 cycles → rsp_valid stays 1, rsp_rdata stays 0x3C, mem_read/mem_write stay 0; completes on the first rsp_ready=1 cycle.
- Reset during WAIT of a read to addr 0 with 2 writes queued → the next cycle shows all outputs at reset values; no response is ever issued; queued writes never reach the memory.
- Counter saturation: 300 writes → wr_count reaches 255 and holds; rd_count stays 0.
- READ_LATENCY=3 build: read addr 17 preloaded 0x81 → mem_data_out sampled 3 cycles after the mem_read cycle; rsp_valid in k+6 with 0x81.
